wb_arbiter: RTL and testbench

- Writeback arbiter that owns the single register-file write port (write address, write data, write enable).
- Merges two result sources: the single-cycle EX result and the long-latency LSU/multi-cycle result.
- LSU results are buffered in a small in-order FIFO while EX holds the port.
- Drives a registered write onto the register file one cycle after a result is accepted, and answers pending-write hazard queries from ID.

---
 rtl/wb_arbiter_if.sv | 41 ++++
 rtl/wb_arbiter.sv | 114 +++++++++++
 tb/tb_wb_arbiter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundle of every non-clock signal around the writeback arbiter.
//   slave  modport : the arbiter's view (results and query in, port/status out)
//   master modport : the pipeline/testbench view (opposite directions)
// Signals:
//   ex_valid/ex_rd/ex_wdata, ex_stall      EX result and its back-pressure
//   lsu_valid/lsu_rd/lsu_wdata, lsu_ready  LSU result handshake
//   rd_waddr/rd_wdata/wen                  registered register-file write port
//   pend_cnt                               LSU FIFO occupancy
//   q_addr/q_hit                           ID pending-write hazard query
interface wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              ex_valid;
  logic [ADDR_W-1:0] ex_rd;
  logic [DATA_W-1:0] ex_wdata;
  logic              ex_stall;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_wdata;
  logic [ADDR_W-1:0] rd_waddr;
  logic [DATA_W-1:0] rd_wdata;
  logic              wen;
  logic [CW-1:0]     pend_cnt;
  logic [ADDR_W-1:0] q_addr;
  logic              q_hit;

  modport slave (
    input  ex_valid, ex_rd, ex_wdata, lsu_valid, lsu_rd, lsu_wdata, q_addr,
    output ex_stall, lsu_ready, rd_waddr, rd_wdata, wen, pend_cnt, q_hit
  );

  modport master (
    output ex_valid, ex_rd, ex_wdata, lsu_valid, lsu_rd, lsu_wdata, q_addr,
    input  ex_stall, lsu_ready, rd_waddr, rd_wdata, wen, pend_cnt, q_hit
  );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the single register-file write port. Merges the single-cycle
// EX result with LSU/multi-cycle results; LSU results that lose to EX wait in
// an in-order FIFO. Accepted results are written one cycle later.
// Ports:
//   clk   core clock, all state on the rising edge
//   rstn  synchronous active-low reset
//   bus   wb_arbiter_if.slave (EX/LSU inputs, RF write port, hazard query)
// Build option:
//   WB_STARVE_GUARD_EN  when defined, after STARVE_MAX consecutive EX wins with
//                       the FIFO non-empty, EX is refused for one cycle so the
//                       FIFO head can drain. Undefined: EX always wins.
module wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rstn,
  wb_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] mem_rd [DEPTH];
  logic [DATA_W-1:0] mem_wd [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     cnt;

  logic              fifo_ne, lsu_hs, ex_win, push, pop, sel;
  logic [ADDR_W-1:0] sel_rd;
  logic [DATA_W-1:0] sel_wd;
  logic [DEPTH-1:0]  ent_hit;

  assign fifo_ne       = (cnt != '0);
  // Ready ignores a same-cycle pop: a full FIFO never pushes and pops together.
  assign bus.lsu_ready = rstn && (cnt != CW'(DEPTH));
  assign bus.pend_cnt  = cnt;
  assign lsu_hs        = bus.lsu_valid && bus.lsu_ready;
  assign ex_win        = bus.ex_valid && !bus.ex_stall;
  // LSU goes into the FIFO unless it can bypass (EX idle and FIFO empty).
  assign push          = lsu_hs && (ex_win || fifo_ne);
  assign pop           = !ex_win && fifo_ne;
  assign sel           = ex_win || fifo_ne || lsu_hs;

  always_comb begin
    sel_rd = bus.ex_rd;
    sel_wd = bus.ex_wdata;
    if (!ex_win && fifo_ne) begin
      sel_rd = mem_rd[rptr];
      sel_wd = mem_wd[rptr];
    end else if (!ex_win) begin
      sel_rd = bus.lsu_rd;
      sel_wd = bus.lsu_wdata;
    end
  end

  // Hazard query: an entry is live when its distance from the head is < cnt,
  // so stale slots left behind by pops never match.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PW-1:0] off;
    assign off        = PW'(i) - rptr;
    assign ent_hit[i] = ({1'b0, off} < cnt) && (mem_rd[i] == bus.q_addr);
  end
  assign bus.q_hit = (bus.q_addr != '0) && (|ent_hit);

  // Payload storage needs no reset; push is already gated off by rstn.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_rd[wptr] <= bus.lsu_rd;
      mem_wd[wptr] <= bus.lsu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr         <= '0;
      rptr         <= '0;
      cnt          <= '0;
      bus.wen      <= 1'b0;
      bus.rd_waddr <= '0;
      bus.rd_wdata <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt     <= cnt + CW'(push) - CW'(pop);
      // x0 results still take their port cycle but never write.
      bus.wen <= sel && (sel_rd != '0);
      if (sel) begin
        bus.rd_waddr <= sel_rd;
        bus.rd_wdata <= sel_wd;
      end
    end
  end

`ifdef WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;
  logic          stall;

  assign stall        = rstn && fifo_ne && (starve == SW'(STARVE_MAX));
  assign bus.ex_stall = stall;

  always_ff @(posedge clk) begin
    if (!rstn || !fifo_ne || stall) starve <= '0;
    else if (ex_win)                starve <= starve + 1'b1;
  end
`else
  // EX is never refused; STARVE_MAX is referenced so the parameter set is
  // identical in both builds (the expression is constant 0).
  assign bus.ex_stall = (STARVE_MAX < 0);
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

  wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(3)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    logic              ex_v;
    logic [ADDR_W-1:0] ex_rd;
    logic              lsu_v;
    logic [ADDR_W-1:0] lsu_rd;
    logic [ADDR_W-1:0] q;
    logic              e_rdy;
    int                e_pend;
    logic              e_hit;
    logic              e_wen;
    logic [ADDR_W-1:0] e_wa;
  } vec_t;

  function automatic vec_t mk(bit exv, int exrd, bit lv, int lrd, int q,
                              bit rdy, int pend, bit hit, bit wen, int wa);
    vec_t v;
    v.ex_v = exv;  v.ex_rd = exrd[ADDR_W-1:0];
    v.lsu_v = lv;  v.lsu_rd = lrd[ADDR_W-1:0];
    v.q = q[ADDR_W-1:0];
    v.e_rdy = rdy; v.e_pend = pend; v.e_hit = hit;
    v.e_wen = wen; v.e_wa = wa[ADDR_W-1:0];
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] exd(int rd);
    return 32'hE000_0000 | DATA_W'(rd);
  endfunction
  function automatic logic [DATA_W-1:0] lsd(int rd);
    return 32'hA000_0000 | DATA_W'(rd);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(int a, logic [DATA_W-1:0] d);
    wr_t w;
    w.a = a[ADDR_W-1:0];
    w.d = d;
    sb.push_back(w);
  endtask

  // Bounded wait for all expected writes to appear.
  task automatic drain(string name);
    for (int i = 0; i < 12 && sb.size() != 0; i++) tick();
    chk(name, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic idle();
    bus.ex_valid  = 1'b0;
    bus.lsu_valid = 1'b0;
    bus.q_addr    = '0;
  endtask

  // Scoreboard: every write the DUT makes must be the next expected one.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wen === 1'b1) begin
        n_chk++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_write: unexpected write addr=%0d data=0x%0h at %0t",
                   bus.rd_waddr, bus.rd_wdata, $time);
        end else begin
          e = sb.pop_front();
          if (bus.rd_waddr !== e.a || bus.rd_wdata !== e.d) begin
            n_fail++;
            $display("FAIL sb_write: got addr=%0d data=0x%0h expected addr=%0d data=0x%0h at %0t",
                     bus.rd_waddr, bus.rd_wdata, e.a, e.d, $time);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tv[13];

  initial begin
    // Contention: EX busy 6 cycles, LSU offers rd1..5; FIFO fills, then drains
    // in order. Expected wen/waddr are the registered result of the prior row.
    tv[0]  = mk(1, 16, 1, 1, 0,  1, 0, 0, 0, 0);
    tv[1]  = mk(1, 17, 1, 2, 0,  1, 1, 0, 1, 16);
    tv[2]  = mk(1, 18, 1, 3, 0,  1, 2, 0, 1, 17);
    tv[3]  = mk(1, 19, 1, 4, 0,  1, 3, 0, 1, 18);
    tv[4]  = mk(1, 20, 1, 5, 3,  0, 4, 1, 1, 19);
    tv[5]  = mk(1, 21, 1, 5, 9,  0, 4, 0, 1, 20);
    tv[6]  = mk(0, 0,  1, 5, 1,  0, 4, 1, 1, 21);
    tv[7]  = mk(0, 0,  1, 5, 1,  1, 3, 0, 1, 1);
    tv[8]  = mk(0, 0,  0, 0, 5,  1, 3, 1, 1, 2);
    tv[9]  = mk(0, 0,  0, 0, 0,  1, 2, 0, 1, 3);
    tv[10] = mk(0, 0,  0, 0, 0,  1, 1, 0, 1, 4);
    tv[11] = mk(0, 0,  0, 0, 0,  1, 0, 0, 1, 5);
    tv[12] = mk(0, 0,  0, 0, 5,  1, 0, 0, 0, 0);

    // ---- reset with both sources active
    rstn = 1'b0;
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd9;  bus.ex_wdata = 32'h9;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd10; bus.lsu_wdata = 32'h10;
    bus.q_addr = '0;
    tick(); tick();
    chk("rst_wen", 32'(bus.wen), 0);
    chk("rst_waddr", 32'(bus.rd_waddr), 0);
    chk("rst_wdata", bus.rd_wdata, 0);
    chk("rst_pend", 32'(bus.pend_cnt), 0);
    chk("rst_lsu_ready", 32'(bus.lsu_ready), 0);
    chk("rst_ex_stall", 32'(bus.ex_stall), 0);
    rstn = 1'b1;
    idle();
    #1;
    chk("rel_lsu_ready", 32'(bus.lsu_ready), 1);
    tick();
    chk("rel_wen", 32'(bus.wen), 0);

    // ---- lone EX
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd5; bus.ex_wdata = 32'hDEADBEEF;
    push_wr(5, 32'hDEADBEEF);
    tick();
    idle();
    chk("ex_wen", 32'(bus.wen), 1);
    chk("ex_waddr", 32'(bus.rd_waddr), 5);
    chk("ex_wdata", bus.rd_wdata, 32'hDEADBEEF);
    tick();
    chk("ex_wen_off", 32'(bus.wen), 0);
    chk("ex_waddr_hold", 32'(bus.rd_waddr), 5);
    drain("ex_drain");

    // ---- LSU bypass
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_wdata = 32'h1234;
    push_wr(7, 32'h1234);
    #1;
    chk("byp_ready", 32'(bus.lsu_ready), 1);
    tick();
    idle();
    chk("byp_wen", 32'(bus.wen), 1);
    chk("byp_waddr", 32'(bus.rd_waddr), 7);
    chk("byp_wdata", bus.rd_wdata, 32'h1234);
    chk("byp_pend", 32'(bus.pend_cnt), 0);
    tick();
    chk("byp_wen_off", 32'(bus.wen), 0);
    drain("byp_drain");

`ifndef WB_STARVE_GUARD_EN
    // ---- contention and order (table)
    for (int r = 16; r <= 21; r++) push_wr(r, exd(r));
    for (int r = 1; r <= 5; r++)   push_wr(r, lsd(r));
    for (int i = 0; i < 13; i++) begin
      bus.ex_valid  = tv[i].ex_v;
      bus.ex_rd     = tv[i].ex_rd;
      bus.ex_wdata  = exd(int'(tv[i].ex_rd));
      bus.lsu_valid = tv[i].lsu_v;
      bus.lsu_rd    = tv[i].lsu_rd;
      bus.lsu_wdata = lsd(int'(tv[i].lsu_rd));
      bus.q_addr    = tv[i].q;
      #1;
      chk($sformatf("row%0d_ready", i), 32'(bus.lsu_ready), 32'(tv[i].e_rdy));
      chk($sformatf("row%0d_pend", i), 32'(bus.pend_cnt), 32'(tv[i].e_pend));
      chk($sformatf("row%0d_qhit", i), 32'(bus.q_hit), 32'(tv[i].e_hit));
      chk($sformatf("row%0d_wen", i), 32'(bus.wen), 32'(tv[i].e_wen));
      if (tv[i].e_wen)
        chk($sformatf("row%0d_waddr", i), 32'(bus.rd_waddr), 32'(tv[i].e_wa));
      tick();
    end
    idle();
    drain("tbl_drain");
`endif

    // ---- x0 destination: accepted, never written
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd0; bus.ex_wdata = 32'h5555;
    tick();
    idle();
    chk("x0_wen", 32'(bus.wen), 0);
    tick();
    drain("x0_drain");

    // ---- reset mid-operation discards buffered entries
    for (int k = 0; k < 3; k++) begin
      bus.ex_valid = 1'b1; bus.ex_rd = 5'd24; bus.ex_wdata = exd(24 + k);
      bus.lsu_valid = 1'b1; bus.lsu_rd = ADDR_W'(25 + k); bus.lsu_wdata = lsd(25 + k);
      push_wr(24, exd(24 + k));
      tick();
    end
    idle();
    bus.q_addr = 5'd26;
    rstn = 1'b0;
    #1;
    chk("mid_pend_pre", 32'(bus.pend_cnt), 3);
    chk("mid_qhit_pre", 32'(bus.q_hit), 1);
    tick();
    rstn = 1'b1;
    #1;
    chk("mid_pend_post", 32'(bus.pend_cnt), 0);
    chk("mid_qhit_post", 32'(bus.q_hit), 0);
    chk("mid_wen_post", 32'(bus.wen), 0);
    repeat (4) tick();
    drain("mid_drain");

    // ---- starve guard: one entry buffered, EX held for 5 cycles
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd12; bus.ex_wdata = exd(12);
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd13; bus.lsu_wdata = lsd(13);
    push_wr(12, exd(12));
    tick();
    bus.lsu_valid = 1'b0;
    bus.ex_rd = 5'd14; bus.ex_wdata = exd(14);
`ifdef WB_STARVE_GUARD_EN
    push_wr(14, exd(14)); push_wr(14, exd(14)); push_wr(14, exd(14));
    push_wr(13, lsd(13)); push_wr(14, exd(14));
`else
    for (int k = 0; k < 5; k++) push_wr(14, exd(14));
    push_wr(13, lsd(13));
`endif
    for (int k = 0; k < 5; k++) begin
      #1;
`ifdef WB_STARVE_GUARD_EN
      chk($sformatf("stv_stall%0d", k), 32'(bus.ex_stall), (k == 3) ? 32'd1 : 32'd0);
      if (k == 4) chk("stv_head_waddr", 32'(bus.rd_waddr), 13);
`else
      chk($sformatf("stv_stall%0d", k), 32'(bus.ex_stall), 32'd0);
      if (k == 4) chk("stv_ex_waddr", 32'(bus.rd_waddr), 14);
`endif
      tick();
    end
    idle();
    drain("stv_drain");

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
